// File: rtl/ram_loader_mar.sv
// Purpose  : RAM address register for the CPU (run mode) and boot loader that
//            streams a byte sequence into RAM[0..RAM_LENGTH-1] (load mode).
// Latency  : MAR updates on the posedge after i_MAR_LOAD; loaded bytes reach RAM
//            one cycle after acceptance, so at most one byte every 2 cycles.
// Backpres.: o_LOAD_READY is high only in WAIT; the loader waits indefinitely
//            for i_LOAD_VALID and never drops an accepted byte.
//
// Ports:
//   i_CLOCK, i_RESET_N   clock (posedge) and asynchronous active-low reset
//   BUS                  shared bus; driven here only while writing a loaded byte
//   i_MAR_LOAD           run mode: MAR <= BUS[ADDRESS_WIDTH-1:0]
//   i_CPU_RAM_IN         run mode: forwarded to o_RAM_BUS_READ
//   o_MAR_DATA           RAM address
//   o_RAM_BUS_READ       RAM bus-capture strobe
//   i_LOAD_START         starts a load (sampled in IDLE only)
//   i_LOAD_DATA/VALID    loader byte stream, o_LOAD_READY handshake
//   o_LOADING            high in every non-IDLE state (CPU must stay off BUS)
//   o_LOAD_DONE          one-cycle pulse after the last byte is written
//   o_CHECKSUM           running byte sum of the load
//
// Build option: define LOADER_CHECKSUM_EN to include the checksum register;
// otherwise o_CHECKSUM is tied to zero.
module ram_loader_mar #(
  parameter int DATA_WIDTH    = 8,
  parameter int RAM_LENGTH    = 16,
  parameter int ADDRESS_WIDTH = $clog2(RAM_LENGTH)
) (
  input  logic                     i_CLOCK,
  input  logic                     i_RESET_N,
  inout  wire  [DATA_WIDTH-1:0]    BUS,
  input  logic                     i_MAR_LOAD,
  input  logic                     i_CPU_RAM_IN,
  output logic [ADDRESS_WIDTH-1:0] o_MAR_DATA,
  output logic                     o_RAM_BUS_READ,
  input  logic                     i_LOAD_START,
  input  logic [DATA_WIDTH-1:0]    i_LOAD_DATA,
  input  logic                     i_LOAD_VALID,
  output logic                     o_LOAD_READY,
  output logic                     o_LOADING,
  output logic                     o_LOAD_DONE,
  output logic [DATA_WIDTH-1:0]    o_CHECKSUM
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Termination compares against the real depth, so non-power-of-2 RAMs
  // stop at RAM_LENGTH-1 rather than at the natural counter wrap.
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(RAM_LENGTH - 1);

  logic [1:0]               state_q;
  logic [1:0]               state_d;
  logic [ADDRESS_WIDTH-1:0] mar_q;
  logic [ADDRESS_WIDTH-1:0] mar_d;
  logic [DATA_WIDTH-1:0]    byte_q;
  logic [DATA_WIDTH-1:0]    byte_d;

  logic in_idle;
  logic in_wait;
  logic in_write;
  logic in_done;
  logic load_accept;
  logic last_byte;

  assign in_idle     = (state_q == ST_IDLE);
  assign in_wait     = (state_q == ST_WAIT);
  assign in_write    = (state_q == ST_WRITE);
  assign in_done     = (state_q == ST_DONE);
  assign load_accept = in_wait && i_LOAD_VALID;
  assign last_byte   = (mar_q == LAST_ADDR);

  // Only the low address bits of BUS are consumed; the reduction keeps the
  // remaining bits visibly intentional.
  wire unused_bus_bits = ^BUS;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    byte_d  = byte_q;
    case (state_q)
      ST_IDLE: begin
        // Load start has priority over a simultaneous CPU MAR load.
        if (i_LOAD_START) begin
          state_d = ST_WAIT;
          mar_d   = '0;
        end else if (i_MAR_LOAD) begin
          mar_d = BUS[ADDRESS_WIDTH-1:0];
        end
      end
      ST_WAIT: begin
        if (load_accept) begin
          byte_d  = i_LOAD_DATA;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // RAM captures at the current MAR on this closing edge; the new MAR
        // only becomes visible afterwards.
        if (last_byte) begin
          mar_d   = '0;
          state_d = ST_DONE;
        end else begin
          mar_d   = mar_q + ADDRESS_WIDTH'(1);
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      byte_q  <= byte_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional checksum
  // ---------------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  // Holds after DONE so software can read it until the next load starts.
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      csum_q <= '0;
    end else if (in_idle && i_LOAD_START) begin
      csum_q <= '0;
    end else if (in_write) begin
      csum_q <= csum_q + byte_q;
    end
  end

  assign o_CHECKSUM = csum_q;
`else
  assign o_CHECKSUM = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // BUS follows the state register, so an asynchronous reset releases it in
  // the same instant.
  assign BUS = in_write ? byte_q : {DATA_WIDTH{1'bz}};

  assign o_MAR_DATA   = mar_q;
  assign o_LOAD_READY = in_wait;
  assign o_LOADING    = !in_idle;
  assign o_LOAD_DONE  = in_done;

  // The CPU pass-through is gated by reset: the state register reads IDLE
  // while reset is held, and the RAM must not capture during that time.
  assign o_RAM_BUS_READ = in_write || (in_idle && i_CPU_RAM_IN && i_RESET_N);

endmodule

// File: tb/tb_ram_loader_mar.sv
`timescale 1ns/1ps
module tb_ram_loader_mar;

  localparam int DW = 8;
  localparam int RL = 16;
  localparam int AW = 4;

  logic          i_CLOCK = 1'b0;
  logic          i_RESET_N;
  wire  [DW-1:0] BUS;
  logic [DW-1:0] bus_drv;
  logic          bus_en;
  logic          i_MAR_LOAD;
  logic          i_CPU_RAM_IN;
  logic [AW-1:0] o_MAR_DATA;
  logic          o_RAM_BUS_READ;
  logic          i_LOAD_START;
  logic [DW-1:0] i_LOAD_DATA;
  logic          i_LOAD_VALID;
  logic          o_LOAD_READY;
  logic          o_LOADING;
  logic          o_LOAD_DONE;
  logic [DW-1:0] o_CHECKSUM;

  int checks = 0;
  int errors = 0;

  assign BUS = bus_en ? bus_drv : {DW{1'bz}};

  always #5 i_CLOCK = ~i_CLOCK;

  ram_loader_mar #(.DATA_WIDTH(DW), .RAM_LENGTH(RL), .ADDRESS_WIDTH(AW)) dut (
    .i_CLOCK        (i_CLOCK),
    .i_RESET_N      (i_RESET_N),
    .BUS            (BUS),
    .i_MAR_LOAD     (i_MAR_LOAD),
    .i_CPU_RAM_IN   (i_CPU_RAM_IN),
    .o_MAR_DATA     (o_MAR_DATA),
    .o_RAM_BUS_READ (o_RAM_BUS_READ),
    .i_LOAD_START   (i_LOAD_START),
    .i_LOAD_DATA    (i_LOAD_DATA),
    .i_LOAD_VALID   (i_LOAD_VALID),
    .o_LOAD_READY   (o_LOAD_READY),
    .o_LOADING      (o_LOADING),
    .o_LOAD_DONE    (o_LOAD_DONE),
    .o_CHECKSUM     (o_CHECKSUM)
  );

  // Behavioural RAM: captures BUS at the current address on every strobe.
  logic [DW-1:0] ram [RL];
  always @(posedge i_CLOCK) begin
    if (o_RAM_BUS_READ) ram[o_MAR_DATA] <= BUS;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_bus"},     32'(BUS), 32'(8'bzzzz_zzzz));
    chk({tag, "_strobe"},  32'(o_RAM_BUS_READ), 32'(0));
    chk({tag, "_ready"},   32'(o_LOAD_READY), 32'(0));
    chk({tag, "_loading"}, 32'(o_LOADING), 32'(0));
    chk({tag, "_done"},    32'(o_LOAD_DONE), 32'(0));
    chk({tag, "_mar"},     32'(o_MAR_DATA), 32'(0));
    chk({tag, "_csum"},    32'(o_CHECKSUM), 32'(0));
  endtask

  // Runs one load from IDLE (called at a negedge). gap_idx/gap_len hold VALID
  // low before a given byte; noise toggles the ignored CPU controls; abort_at
  // asserts reset in the middle of that byte's WRITE cycle.
  task automatic do_load(input logic [7:0] base, input int gap_idx, input int gap_len,
                         input bit noise, input int abort_at,
                         output int n_wr, output int n_done, output int span);
    int idx, cyc, first_acc, done_cyc, last_wr, gap, exp_sp;
    n_wr = 0; n_done = 0; span = -1;
    idx = 0; cyc = 0; first_acc = -1; done_cyc = -1; last_wr = -1; gap = 0;
    // Start together with a MAR load of 0x35: start must win, MAR ends at 0.
    bus_en = 1'b1; bus_drv = 8'h35; i_MAR_LOAD = 1'b1; i_LOAD_START = 1'b1;
    @(negedge i_CLOCK);
    bus_en = 1'b0; i_MAR_LOAD = 1'b0; i_LOAD_START = 1'b0;
    chk("start_mar_zero", 32'(o_MAR_DATA), 32'(0));
    chk("start_loading", 32'(o_LOADING), 32'(1));
    while (cyc < 200) begin
      if (!o_LOADING) break;
      i_LOAD_VALID = 1'b0;
      if (noise) begin
        i_MAR_LOAD   = 1'($urandom_range(0, 1));
        i_CPU_RAM_IN = 1'($urandom_range(0, 1));
        i_LOAD_START = 1'($urandom_range(0, 1));
      end
      #1;
      if (o_LOAD_READY) begin
        chk("wait_mar", 32'(o_MAR_DATA), 32'(idx));
        chk("wait_strobe_low", 32'(o_RAM_BUS_READ), 32'(0));
        if (idx == gap_idx && gap < gap_len) begin
          gap++;
        end else if (idx < RL) begin
          i_LOAD_VALID = 1'b1;
          i_LOAD_DATA  = 8'(base + idx);
          if (first_acc < 0) first_acc = cyc;
          idx++;
        end
      end else if (o_RAM_BUS_READ) begin
        chk("write_mar", 32'(o_MAR_DATA), 32'(n_wr));
        chk("write_bus", 32'(BUS), 32'(8'(base + n_wr)));
        if (last_wr >= 0) begin
          exp_sp = (n_wr == gap_idx && gap_len > 0) ? 2 + gap_len : 2;
          chk("write_spacing", 32'(cyc - last_wr), 32'(exp_sp));
        end
        if (n_wr == abort_at) begin
          i_RESET_N = 1'b0; i_CPU_RAM_IN = 1'b1; i_MAR_LOAD = 1'b0; i_LOAD_START = 1'b0;
          #1;
          chk_idle_outputs("abort_now");
          repeat (3) begin
            @(negedge i_CLOCK);
            chk_idle_outputs("abort_hold");
          end
          i_CPU_RAM_IN = 1'b0;
          i_RESET_N = 1'b1;
          return;
        end
        n_wr++;
        last_wr = cyc;
      end else if (o_LOAD_DONE) begin
        chk("done_mar", 32'(o_MAR_DATA), 32'(0));
        chk("done_strobe_low", 32'(o_RAM_BUS_READ), 32'(0));
        n_done++;
        done_cyc = cyc;
      end
      @(negedge i_CLOCK);
      cyc++;
    end
    i_MAR_LOAD = 1'b0; i_CPU_RAM_IN = 1'b0; i_LOAD_START = 1'b0; i_LOAD_VALID = 1'b0;
    // Inclusive cycle count: first accepting WAIT cycle through the DONE cycle.
    if (first_acc >= 0 && done_cyc >= 0) span = done_cyc - first_acc + 1;
  endtask

  task automatic check_after_load(input string tag, input logic [7:0] base,
                                  input int n_wr, input int n_done, input int span,
                                  input int exp_span);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < RL; i++) cs = 8'(cs + 8'(base + i));
`ifndef LOADER_CHECKSUM_EN
    cs = 8'h00;
`endif
    chk({tag, "_writes"}, 32'(n_wr), 32'(RL));
    chk({tag, "_done_pulses"}, 32'(n_done), 32'(1));
    chk({tag, "_span"}, 32'(span), 32'(exp_span));
    chk({tag, "_mar_after"}, 32'(o_MAR_DATA), 32'(0));
    chk({tag, "_loading_after"}, 32'(o_LOADING), 32'(0));
    chk({tag, "_bus_after"}, 32'(BUS), 32'(8'bzzzz_zzzz));
    chk({tag, "_csum"}, 32'(o_CHECKSUM), 32'(cs));
    for (int i = 0; i < RL; i++) chk({tag, "_ram"}, 32'(ram[i]), 32'(8'(base + i)));
  endtask

  initial begin
    int nw, nd, sp;
    i_RESET_N = 1'b0; bus_en = 1'b0; bus_drv = '0;
    i_MAR_LOAD = 1'b0; i_CPU_RAM_IN = 1'b0; i_LOAD_START = 1'b0;
    i_LOAD_DATA = '0; i_LOAD_VALID = 1'b0;

    // Reset state, held for 3 cycles
    #2;
    chk_idle_outputs("reset");
    repeat (3) begin
      @(negedge i_CLOCK);
      chk_idle_outputs("reset_hold");
    end
    i_RESET_N = 1'b1;

    // Run mode: MAR load takes BUS[3:0] only
    bus_en = 1'b1; bus_drv = 8'h3A; i_MAR_LOAD = 1'b1;
    @(negedge i_CLOCK);
    i_MAR_LOAD = 1'b0;
    chk("run_mar", 32'(o_MAR_DATA), 32'(4'hA));
    chk("run_loading", 32'(o_LOADING), 32'(0));
    i_CPU_RAM_IN = 1'b1; #1;
    chk("run_strobe_on", 32'(o_RAM_BUS_READ), 32'(1));
    i_CPU_RAM_IN = 1'b0; #1;
    chk("run_strobe_off", 32'(o_RAM_BUS_READ), 32'(0));
    bus_en = 1'b0;
    @(negedge i_CLOCK);

    // Full load of 0x10..0x1F, VALID held high: 2*16+1 cycles
    do_load(8'h10, -1, 0, 1'b0, -1, nw, nd, sp);
    check_after_load("full", 8'h10, nw, nd, sp, 33);

    // Same length with ignored controls toggling throughout
    do_load(8'hA0, -1, 0, 1'b1, -1, nw, nd, sp);
    check_after_load("isolate", 8'hA0, nw, nd, sp, 33);

    // VALID low for 4 cycles before byte 3: span grows by 4
    do_load(8'h10, 3, 4, 1'b0, -1, nw, nd, sp);
    check_after_load("backpr", 8'h10, nw, nd, sp, 37);

    // Reset during the write of byte 5: bytes 0..4 written, byte 5 not
    do_load(8'h50, -1, 0, 1'b0, 5, nw, nd, sp);
    chk("abort_writes", 32'(nw), 32'(5));
    chk("abort_no_done", 32'(nd), 32'(0));
    for (int i = 0; i < 5; i++) chk("abort_ram_new", 32'(ram[i]), 32'(8'(8'h50 + i)));
    chk("abort_ram5_old", 32'(ram[5]), 32'(8'h15));
    @(negedge i_CLOCK);
    chk_idle_outputs("abort_after");

    // A fresh load after the abort completes normally
    do_load(8'h60, -1, 0, 1'b0, -1, nw, nd, sp);
    check_after_load("reload", 8'h60, nw, nd, sp, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
